// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, datapath defaults and
// the condition-code bit order used by the CC register.
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Packed so the CC register sees {zf, sf, of} from MSB to LSB.
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// CHUNK-bit ripple adder slice built from xor/and/or full-adder cells;
// fed with the inverted subtrahend it performs one slice of a - b.
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] nb_i,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a_i[i] ^ nb_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & nb_i[i]) | (c[i] & (a_i[i] ^ nb_i[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/seq_sub64.sv
// Multi-cycle chunked subtractor y = a - b with Y86 condition codes and
// borrow; one CHUNK-bit slice is resolved per BUSY cycle.
module seq_sub64
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CHUNK = ALU_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             borrow
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = $clog2(NCHUNK) + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; in_ready is high only in IDLE, out_valid holds in DONE until
    // out_ready, and the payload stays stable while valid is waiting.
    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  nb_q;
    logic [WIDTH-1:0]  y_q;
    logic              a_sign;
    logic              b_sign;
    logic              carry;
    logic [CW-1:0]     cnt;
    cc_t               cc_q;
    logic              borrow_q;
    logic              out_valid_q;

    logic [CHUNK-1:0]  sum;
    logic              cout;
    logic [WIDTH-1:0]  y_next;
    logic              last_chunk;

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i  (a_q[CHUNK-1:0]),
        .nb_i (nb_q[CHUNK-1:0]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    // Operands shift down one slice per cycle while results shift in from
    // the top, so after NCHUNK cycles slice k sits at y[k*CHUNK +: CHUNK].
    assign y_next     = {sum, y_q[WIDTH-1:CHUNK]};
    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            y_q         <= '0;
            a_sign      <= 1'b0;
            b_sign      <= 1'b0;
            carry       <= 1'b0;
            cnt         <= '0;
            cc_q        <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        nb_q   <= ~b;
                        a_sign <= a[WIDTH-1];
                        b_sign <= b[WIDTH-1];
                        carry  <= 1'b1;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> CHUNK;
                    nb_q  <= nb_q >> CHUNK;
                    y_q   <= y_next;
                    carry <= cout;
                    cnt   <= cnt + CW'(1);
                    if (last_chunk) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        cc_q.zf     <= (y_next == '0);
                        cc_q.sf     <= y_next[WIDTH-1];
                        cc_q.of     <= (a_sign != b_sign) && (y_next[WIDTH-1] != a_sign);
                        borrow_q    <= ~cout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zf        = cc_q.zf;
    assign sf        = cc_q.sf;
    assign of        = cc_q.of;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_seq_sub64.sv
// Bench for seq_sub64: directed vector table, stall and reset sequences,
// then random operands checked against an arithmetic reference model.
module tb_seq_sub64;

    localparam int W = 64;
    localparam int LAT = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zf;
    logic         sf;
    logic         of;
    logic         borrow;

    int n_cmp = 0;
    int n_bad = 0;

    // {borrow, of, sf, zf, y}
    logic [W+3:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         zf;
        logic         sf;
        logic         of;
        logic         borrow;
        int           stall;
    } vec_t;

    vec_t vecs[6];

    seq_sub64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: wide unsigned and sign-extended differences.
    function automatic logic [W+3:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0] ud;
        logic [W:0] sd;
        logic [W-1:0] r;
        ud = {1'b0, av} - {1'b0, bv};
        sd = {av[W-1], av} - {bv[W-1], bv};
        r  = ud[W-1:0];
        return {ud[W], (sd[W] != sd[W-1]), r[W-1], (r == '0), r};
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int stall);
        logic [W+3:0] e;
        int lat;
        bit got;
        @(negedge clk);
        chk("in_ready_idle", {67'd0, in_ready}, 68'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = rnd64();
        b = rnd64();
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) got = 1;
            else chk("in_ready_busy", {67'd0, in_ready}, 68'd0);
        end
        chk("latency", 68'(lat), 68'(LAT));
        e = exp_q.pop_front();
        if (got) chk("result", {borrow, of, sf, zf, y}, e);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            in_valid = s[0];
            a = rnd64();
            b = rnd64();
            @(posedge clk);
            #1;
            chk("stall_valid", {67'd0, out_valid}, 68'd1);
            chk("stall_in_ready", {67'd0, in_ready}, 68'd0);
            chk("stall_result", {borrow, of, sf, zf, y}, e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", {67'd0, out_valid}, 68'd0);
        chk("release_in_ready", {67'd0, in_ready}, 68'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
                    1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                    1'b0, 1'b1, 1'b1, 1'b1, 0};
        vecs[4] = '{64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF,
                    1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0,
                    1'b1, 1'b0, 1'b0, 1'b0, 5};

        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = rnd64();
        b = rnd64();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {borrow, of, sf, zf, y}, '0);
        chk("reset_valid", {67'd0, out_valid}, 68'd0);
        chk("reset_in_ready", {67'd0, in_ready}, 68'd1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({vecs[i].borrow, vecs[i].of, vecs[i].sf, vecs[i].zf, vecs[i].y});
            run_op(vecs[i].a, vecs[i].b, vecs[i].stall);
        end

        // Reset three cycles into BUSY discards the operation.
        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF;
        b = 64'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_out", {borrow, of, sf, zf, y}, '0);
        chk("midreset_valid", {67'd0, out_valid}, 68'd0);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", {67'd0, in_ready}, 68'd1);
        chk("post_reset_valid", {67'd0, out_valid}, 68'd0);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 64'd6});
        run_op(64'd10, 64'd4, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = rnd64();
            rb = rnd64();
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: ra = {1'b1, 63'd0};
                2: rb = ra + W'($urandom_range(0, 2));
                default: ;
            endcase
            exp_q.push_back(model(ra, rb));
            run_op(ra, rb, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_sub64.md
Name: seq_sub64

Overview:
- Multi-cycle chunked 64-bit subtractor computing y = a - b, with Y86 condition codes ZF, SF, OF and a borrow flag.
- The inverse operation to the combinational ripple-carry adder in the ALU path.
- Used by the ALU for SUBQ and for compare-style operations.
- Processes CHUNK bits per cycle with a registered carry, trading latency for area.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
WIDTH, 64, operand/result width; WIDTH % CHUNK must equal 0
CHUNK, 8, bits processed per BUSY cycle
NCHUNK, WIDTH/CHUNK (derived localparam, 8), number of BUSY cycles

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b valid
in_ready  output  1  block can accept operands; equals (state==IDLE)
a  input  WIDTH  minuend, two's complement
b  input  WIDTH  subtrahend, two's complement
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  a - b modulo 2^WIDTH
zf  output  1  y == 0
sf  output  1  y[WIDTH-1]
of  output  1  signed overflow
borrow  output  1  unsigned borrow, i.e. a < b unsigned (= ~carry out)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, out_valid=0, y=0, zf=sf=of=borrow=0.
  - Internal operand regs, carry and counter are cleared.
  - Inputs are ignored while rst_n is low.
  - In-flight operations are discarded, with no partial result.
- States:
  - IDLE -> BUSY when in_valid && in_ready.
  - BUSY -> DONE after NCHUNK chunk cycles.
  - DONE -> IDLE when out_ready.
- Accept (IDLE, in_valid=1):
  - Latch a and ~b.
  - carry=1 (two's-complement +1).
  - cnt=0.
- BUSY, each cycle:
  - Chunk k=cnt: {c, y[k*CHUNK +: CHUNK]} = a[k*CHUNK +: CHUNK] + nb[k*CHUNK +: CHUNK] + carry.
  - carry <= c, cnt <= cnt+1.
  - Transition to DONE on the cycle cnt==NCHUNK-1 is processed.
- Entering DONE, register flags with out_valid=1:
  - zf = (y==0), sf = y[WIDTH-1].
  - of = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]).
  - borrow = ~final carry.
- Latency: out_valid rises exactly NCHUNK clock edges after the accept edge (8 for defaults).
- DONE:
  - y and flags are held stable while out_valid=1 && out_ready=0 (unbounded stall).
  - On out_ready=1: out_valid <= 0 at that edge, state -> IDLE.
  - y and flags keep their last values after the handshake; they are don't-care when out_valid=0.
- in_ready=0 in BUSY and DONE. No overlap: a new accept is possible only in the cycle after the DONE->IDLE edge. Throughput is one op per NCHUNK+2 cycles minimum.
- in_valid asserted during BUSY/DONE is ignored and not queued; the producer must hold it until in_ready.
- out_ready high in IDLE/BUSY has no effect.
- Wrap-around: all arithmetic is modulo 2^WIDTH; the final carry is used only for borrow.
- The counter width is clog2(NCHUNK)+1; no wrap occurs within an operation.

Decomposition:
- Shared package/include (alu_pkg):
  - state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10
  - WIDTH default constant
  - NCHUNK computation
  - the flag bit order {zf, sf, of} used by the CC register
- One sub-module, sub_chunk: CHUNK-bit adder slice with ports a_i, nb_i, cin, sum, cout. It is built from the same xor/and/or full-adder cell style as the existing adder and instantiated once. The FSM, counter and operand registers stay in seq_sub64.

Test Plan:
1. a=5, b=3 -> y=2, zf=0, sf=0, of=0, borrow=0; out_valid exactly 8 edges after accept.
2. a=3, b=5 -> y=0xFFFF_FFFF_FFFF_FFFE, sf=1, borrow=1, of=0, zf=0.
3. a=0x8000_0000_0000_0000, b=1 -> y=0x7FFF_FFFF_FFFF_FFFF, of=1, sf=0, borrow=0. Also a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> y=0x8000_0000_0000_0000, of=1, sf=1, borrow=1.
4. Cross-chunk borrow chain: a=0x0000_0001_0000_0000, b=1 -> y=0x0000_0000_FFFF_FFFF, zf=0, borrow=0.
5. a=b=0x1234_5678_9ABC_DEF0 with out_ready held low 5 cycles after out_valid -> y=0 and zf=1 stable all 5 cycles, in_ready=0 throughout, and in_valid pulses during the stall are ignored. Release out_ready -> IDLE next edge, in_ready=1.
6. Assert rst_n low 3 cycles into BUSY -> out_valid=0, y=0, all flags 0 immediately; in_ready=1 after release. A following a=10, b=4 yields y=6 with correct 8-cycle latency.
